// File: rtl/aes_pkg.sv
// Shared AES constants, MixColumns FSM encoding and GF(2^8) helpers (poly 0x11B).
package aes_pkg;

  localparam int         AES_WORD  = 8;
  localparam int         AES_BYTES = 16;
  localparam logic [7:0] AES_POLY  = 8'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_COL  = 2'd2,
    ST_DONE = 2'd3
  } mc_state_t;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

  // Shift-and-add multiply; with a constant c the unused partial products fold away.
  function automatic logic [7:0] gf_mul_const(input logic [7:0] x, input logic [7:0] c);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = x;
    for (int i = 0; i < 8; i++) begin
      acc = acc ^ (c[i] ? p : 8'h00);
      p   = xtime(p);
    end
    return acc;
  endfunction

endpackage

// File: rtl/mix_single_column.sv
// Combinational mix of one 32-bit column {a0,a1,a2,a3} (a0 in the top byte).
// AES_INV_MIX_COLUMNS_EN adds the inv select for InvMixColumns coefficients.
module mix_single_column
  import aes_pkg::*;
(
  input  logic [31:0] col_in,
`ifdef AES_INV_MIX_COLUMNS_EN
  input  logic        inv,
`endif
  output logic [31:0] col_out
);

  logic [7:0] a0_s, a1_s, a2_s, a3_s;
  logic [7:0] x0_s, x1_s, x2_s, x3_s;
  logic [31:0] fwd_s;

  assign a0_s = col_in[31:24];
  assign a1_s = col_in[23:16];
  assign a2_s = col_in[15:8];
  assign a3_s = col_in[7:0];

  assign x0_s = xtime(a0_s);
  assign x1_s = xtime(a1_s);
  assign x2_s = xtime(a2_s);
  assign x3_s = xtime(a3_s);

  // Forward coefficients {2,3,1,1}, rotated one byte per output row.
  assign fwd_s[31:24] = x0_s ^ (x1_s ^ a1_s) ^ a2_s ^ a3_s;
  assign fwd_s[23:16] = a0_s ^ x1_s ^ (x2_s ^ a2_s) ^ a3_s;
  assign fwd_s[15:8]  = a0_s ^ a1_s ^ x2_s ^ (x3_s ^ a3_s);
  assign fwd_s[7:0]   = (x0_s ^ a0_s) ^ a1_s ^ a2_s ^ x3_s;

`ifdef AES_INV_MIX_COLUMNS_EN
  logic [31:0] inv_s;

  assign inv_s[31:24] = gf_mul_const(a0_s, 8'h0E) ^ gf_mul_const(a1_s, 8'h0B)
                      ^ gf_mul_const(a2_s, 8'h0D) ^ gf_mul_const(a3_s, 8'h09);
  assign inv_s[23:16] = gf_mul_const(a0_s, 8'h09) ^ gf_mul_const(a1_s, 8'h0E)
                      ^ gf_mul_const(a2_s, 8'h0B) ^ gf_mul_const(a3_s, 8'h0D);
  assign inv_s[15:8]  = gf_mul_const(a0_s, 8'h0D) ^ gf_mul_const(a1_s, 8'h09)
                      ^ gf_mul_const(a2_s, 8'h0E) ^ gf_mul_const(a3_s, 8'h0B);
  assign inv_s[7:0]   = gf_mul_const(a0_s, 8'h0B) ^ gf_mul_const(a1_s, 8'h0D)
                      ^ gf_mul_const(a2_s, 8'h09) ^ gf_mul_const(a3_s, 8'h0E);

  // Direction select between forward and inverse column results.
  always_comb begin
    col_out = fwd_s;
    if (inv) begin
      col_out = inv_s;
    end else begin
      col_out = fwd_s;
    end
  end
`else
  assign col_out = fwd_s;
`endif

endmodule

// File: rtl/mix_columns_serial.sv
// Serial AES MixColumns: one column per cycle, result held until the next operation.
// AES_INV_MIX_COLUMNS_EN adds the inv port (captured with Data) for InvMixColumns.
module mix_columns_serial
  import aes_pkg::*;
#(
  parameter int word_size  = AES_WORD,
  parameter int array_size = AES_BYTES
)
(
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
`ifdef AES_INV_MIX_COLUMNS_EN
  input  logic                             inv,
`endif
  input  logic [word_size*array_size-1:0]  Data,
  output logic [word_size*array_size-1:0]  Mixed_Data,
  output logic                             done,
  output logic                             busy
);

  // Byte 0 sits in the most significant byte, so column c occupies bits [127-32c -: 32].
  mc_state_t    state_r, state_s;
  logic [1:0]   col_r;
  logic [127:0] data_r;
  logic [127:0] mixed_r;
  logic         done_r;
  logic         busy_r;
  logic [31:0]  col_in_s;
  logic [31:0]  col_out_s;
`ifdef AES_INV_MIX_COLUMNS_EN
  logic         inv_r;
`endif

  // Select the holding-register column addressed by the counter.
  always_comb begin
    col_in_s = 32'h0000_0000;
    case (col_r)
      2'd0:    col_in_s = data_r[127:96];
      2'd1:    col_in_s = data_r[95:64];
      2'd2:    col_in_s = data_r[63:32];
      default: col_in_s = data_r[31:0];
    endcase
  end

  mix_single_column u_mix (
    .col_in  (col_in_s),
`ifdef AES_INV_MIX_COLUMNS_EN
    .inv     (inv_r),
`endif
    .col_out (col_out_s)
  );

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (en) begin
          state_s = ST_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: state_s = ST_COL;
      ST_COL: begin
        if (col_r == 2'd3) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_COL;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State, counter, holding and result registers; done/busy registered from next state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      col_r   <= 2'd0;
      data_r  <= 128'd0;
      mixed_r <= 128'd0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
`ifdef AES_INV_MIX_COLUMNS_EN
      inv_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      done_r  <= (state_s == ST_DONE);
      busy_r  <= (state_s == ST_LOAD) || (state_s == ST_COL);
      case (state_r)
        ST_IDLE: begin
          if (en) begin
            data_r <= Data;
`ifdef AES_INV_MIX_COLUMNS_EN
            inv_r  <= inv;
`endif
          end
        end
        ST_LOAD: col_r <= 2'd0;
        ST_COL: begin
          case (col_r)
            2'd0:    mixed_r[127:96] <= col_out_s;
            2'd1:    mixed_r[95:64]  <= col_out_s;
            2'd2:    mixed_r[63:32]  <= col_out_s;
            default: mixed_r[31:0]   <= col_out_s;
          endcase
          col_r <= col_r + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign Mixed_Data = mixed_r;
  assign done       = done_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_mix_columns_serial.sv
// Directed self-checking bench for mix_columns_serial (define AES_INV_MIX_COLUMNS_EN for the inverse case).
module tb_mix_columns_serial;

  localparam logic [127:0] COL_IN   = 128'hdb135345_00000000_00000000_00000000;
  localparam logic [127:0] COL_OUT  = 128'h8e4da1bc_00000000_00000000_00000000;
  localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] FIPS_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
  localparam logic [127:0] FIX_IN   = 128'h01010101_c6c6c6c6_d4d4d4d5_2d26314c;
  localparam logic [127:0] FIX_OUT  = 128'h01010101_c6c6c6c6_d5d5d7d6_4d7ebdf8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic [127:0] Data = 128'd0;
  logic [127:0] Mixed_Data;
  logic         done;
  logic         busy;
`ifdef AES_INV_MIX_COLUMNS_EN
  logic         inv = 1'b0;
`endif

  int err_cnt = 0;
  int chk_cnt = 0;

  mix_columns_serial dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
`ifdef AES_INV_MIX_COLUMNS_EN
    .inv        (inv),
`endif
    .Data       (Data),
    .Mixed_Data (Mixed_Data),
    .done       (done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [127:0] act, input logic [127:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One en pulse; lat = posedges after the drive edge until done is seen (6 expected).
  task automatic run_op(input logic [127:0] d, input logic inv_v, output int lat, output logic busy_load);
    @(posedge clk); #1;
    Data = d;
    en   = 1'b1;
`ifdef AES_INV_MIX_COLUMNS_EN
    inv  = inv_v;
`endif
    lat       = 0;
    busy_load = 1'b0;
    while (lat < 20) begin
      @(posedge clk); #1;
      en = 1'b0;
      lat++;
      if (lat == 1) busy_load = busy;
      if (done) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   lat;
    logic bl;
    int   first_k;
    int   second_k;

    repeat (3) @(posedge clk);
    #1;
    check_value("reset_mixed", Mixed_Data, 128'd0);
    check_value("reset_done", {127'd0, done}, 128'd0);
    check_value("reset_busy", {127'd0, busy}, 128'd0);
    rst = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check_value("idle_no_en_busy", {127'd0, busy}, 128'd0);

    // Single column vector
    run_op(COL_IN, 1'b0, lat, bl);
    check_value("col_latency", 128'(lat), 128'd6);
    check_value("col_busy_load", {127'd0, bl}, 128'd1);
    check_value("col_result", Mixed_Data, COL_OUT);
    check_value("col_done_busy", {127'd0, busy}, 128'd0);
    @(posedge clk); #1;
    check_value("col_done_pulse", {127'd0, done}, 128'd0);

    // FIPS-197 round 1
    run_op(FIPS_IN, 1'b0, lat, bl);
    check_value("fips_latency", 128'(lat), 128'd6);
    check_value("fips_result", Mixed_Data, FIPS_OUT);
    @(posedge clk); #1;
    check_value("fips_done_pulse", {127'd0, done}, 128'd0);

    // Fixed-point columns, then hold check
    run_op(FIX_IN, 1'b0, lat, bl);
    check_value("fix_result", Mixed_Data, FIX_OUT);
    repeat (4) @(posedge clk);
    #1;
    check_value("fix_hold", Mixed_Data, FIX_OUT);

    // en held high; Data changed mid-operation
    first_k  = -1;
    second_k = -1;
    @(posedge clk); #1;
    Data = FIPS_IN;
    en   = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 2) Data = FIX_IN;
      if (done) begin
        if (first_k < 0) begin
          first_k = k;
          check_value("held_first_result", Mixed_Data, FIPS_OUT);
        end else begin
          second_k = k;
          check_value("held_second_result", Mixed_Data, FIX_OUT);
        end
      end
      if (second_k >= 0) break;
    end
    en = 1'b0;
    check_value("held_first_latency", 128'(first_k), 128'd6);
    check_value("held_second_latency", 128'(second_k), 128'd13);

    // Reset while processing column 2
    @(posedge clk); #1;
    Data = FIPS_IN;
    en   = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_value("pre_reset_busy", {127'd0, busy}, 128'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    check_value("midreset_mixed", Mixed_Data, 128'd0);
    check_value("midreset_busy", {127'd0, busy}, 128'd0);
    check_value("midreset_done", {127'd0, done}, 128'd0);
    rst = 1'b1;
    run_op(COL_IN, 1'b0, lat, bl);
    check_value("post_reset_latency", 128'(lat), 128'd6);
    check_value("post_reset_result", Mixed_Data, COL_OUT);

`ifdef AES_INV_MIX_COLUMNS_EN
    // Inverse direction
    run_op(FIPS_OUT, 1'b1, lat, bl);
    check_value("inv_latency", 128'(lat), 128'd6);
    check_value("inv_result", Mixed_Data, FIPS_IN);
    run_op(FIPS_IN, 1'b0, lat, bl);
    check_value("inv_back_to_fwd", Mixed_Data, FIPS_OUT);
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
